// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 execute datapath.
package riscv_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int REG_IDX_W_DEFAULT = 5;

    // funct3 encodings the execute stage understands
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // One-hot ALU operation select; all-zero means the ALU outputs 0
    typedef struct packed {
        logic add_en;
        logic sub_en;
        logic xor_en;
        logic or_en;
        logic and_en;
    } alu_op_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, WB forwarding source, pipeline control and EX/MEM outputs.
interface ex_stage_if #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) ();
    logic                 id_valid;
    logic [REG_IDX_W-1:0] id_rs1_idx;
    logic [REG_IDX_W-1:0] id_rs2_idx;
    logic [XLEN-1:0]      id_rs1_val;
    logic [XLEN-1:0]      id_rs2_val;
    logic [XLEN-1:0]      id_imm;
    logic                 id_use_imm;
    logic [2:0]           id_funct3;
    logic                 id_funct7b5;
    logic [REG_IDX_W-1:0] id_rd_idx;
    logic                 id_reg_write;
    logic [REG_IDX_W-1:0] wb_rd_idx;
    logic                 wb_reg_write;
    logic [XLEN-1:0]      wb_data;
    logic                 stall;
    logic                 flush;
    logic                 ex_valid;
    logic [REG_IDX_W-1:0] ex_rd_idx;
    logic                 ex_reg_write;
    logic [XLEN-1:0]      ex_result;
    logic [XLEN-1:0]      ex_rs2_fwd;
    logic                 ex_illegal;
    logic                 illegal_sticky;

    // Upstream pipeline side: drives ID/WB/control, observes EX/MEM
    modport master (
        output id_valid, id_rs1_idx, id_rs2_idx, id_rs1_val, id_rs2_val, id_imm,
               id_use_imm, id_funct3, id_funct7b5, id_rd_idx, id_reg_write,
               wb_rd_idx, wb_reg_write, wb_data, stall, flush,
        input  ex_valid, ex_rd_idx, ex_reg_write, ex_result, ex_rs2_fwd,
               ex_illegal, illegal_sticky
    );

    // Execute stage side
    modport slave (
        input  id_valid, id_rs1_idx, id_rs2_idx, id_rs1_val, id_rs2_val, id_imm,
               id_use_imm, id_funct3, id_funct7b5, id_rd_idx, id_reg_write,
               wb_rd_idx, wb_reg_write, wb_data, stall, flush,
        output ex_valid, ex_rd_idx, ex_reg_write, ex_result, ex_rs2_fwd,
               ex_illegal, illegal_sticky
    );
endinterface

// File: rtl/alu.sv
// Integer ALU driven by a one-hot operation select; no enable yields 0.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    // Arithmetic wraps; no carry or overflow is reported
    always_comb begin
        y = '0;
        if (op.add_en)      y = a + b;
        else if (op.sub_en) y = a - b;
        else if (op.xor_en) y = a ^ b;
        else if (op.or_en)  y = a | b;
        else if (op.and_en) y = a & b;
    end

endmodule

// File: rtl/alu_decode.sv
// funct3/funct7 to one-hot ALU enable decode with unsupported-op detection.
module alu_decode
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       use_imm,
    input  logic       valid,
    output alu_op_t    op,
    output logic       illegal
);

    // Bit 30 only selects SUB for register-register ops; ADDI ignores it
    always_comb begin
        op      = '0;
        illegal = 1'b0;
        if (valid) begin
            case (funct3)
                F3_ADD_SUB: begin
                    if (!use_imm && funct7b5) op.sub_en = 1'b1;
                    else                      op.add_en = 1'b1;
                end
                F3_XOR:  op.xor_en = 1'b1;
                F3_OR:   op.or_en  = 1'b1;
                F3_AND:  op.and_en = 1'b1;
                default: illegal   = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, and the EX/MEM pipeline register.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int REG_IDX_W = REG_IDX_W_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("ex_stage: XLEN must be 32 to match alu");
    end

    logic                 ex_valid_q;
    logic [REG_IDX_W-1:0] ex_rd_q;
    logic                 ex_rw_q;
    logic [XLEN-1:0]      ex_result_q;
    logic [XLEN-1:0]      ex_rs2_q;
    logic                 ex_illegal_q;
    logic                 sticky_q;

    logic                 ex_fwd_ok;
    logic                 wb_fwd_ok;
    logic [XLEN-1:0]      rs1_fwd;
    logic [XLEN-1:0]      rs2_fwd;
    logic [XLEN-1:0]      arg2;
    logic [XLEN-1:0]      alu_y;
    alu_op_t              op;
    logic                 illegal;

    // A nonzero rd is required, so a hit implies the source index is nonzero
    // and x0 never forwards. EX/MEM is younger than WB and wins.
    assign ex_fwd_ok = ex_valid_q && ex_rw_q && (ex_rd_q != '0);
    assign wb_fwd_ok = bus.wb_reg_write && (bus.wb_rd_idx != '0);

    assign rs1_fwd = (ex_fwd_ok && ex_rd_q == bus.id_rs1_idx)        ? ex_result_q :
                     (wb_fwd_ok && bus.wb_rd_idx == bus.id_rs1_idx)  ? bus.wb_data :
                                                                      bus.id_rs1_val;
    assign rs2_fwd = (ex_fwd_ok && ex_rd_q == bus.id_rs2_idx)        ? ex_result_q :
                     (wb_fwd_ok && bus.wb_rd_idx == bus.id_rs2_idx)  ? bus.wb_data :
                                                                      bus.id_rs2_val;

    assign arg2 = bus.id_use_imm ? bus.id_imm : rs2_fwd;

    alu_decode u_dec (
        .funct3   (bus.id_funct3),
        .funct7b5 (bus.id_funct7b5),
        .use_imm  (bus.id_use_imm),
        .valid    (bus.id_valid),
        .op       (op),
        .illegal  (illegal)
    );

    alu #(.XLEN(XLEN)) u_alu (
        .op (op),
        .a  (rs1_fwd),
        .b  (arg2),
        .y  (alu_y)
    );

    // EX/MEM register: reset > flush > stall(hold) > capture.
    // Flush leaves data fields as-is since they are dead once valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_rd_q      <= '0;
            ex_rw_q      <= 1'b0;
            ex_result_q  <= '0;
            ex_rs2_q     <= '0;
            ex_illegal_q <= 1'b0;
            sticky_q     <= 1'b0;
        end else if (bus.flush) begin
            ex_valid_q   <= 1'b0;
            ex_rw_q      <= 1'b0;
            ex_illegal_q <= 1'b0;
        end else if (!bus.stall) begin
            ex_valid_q   <= bus.id_valid;
            ex_rd_q      <= bus.id_rd_idx;
            ex_rw_q      <= bus.id_valid && bus.id_reg_write;
            ex_result_q  <= alu_y;
            ex_rs2_q     <= rs2_fwd;
            ex_illegal_q <= bus.id_valid && illegal;
            if (bus.id_valid && illegal) sticky_q <= 1'b1;
        end
    end

    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_rd_idx      = ex_rd_q;
    assign bus.ex_reg_write   = ex_rw_q;
    assign bus.ex_result      = ex_result_q;
    assign bus.ex_rs2_fwd     = ex_rs2_q;
    assign bus.ex_illegal     = ex_illegal_q;
    assign bus.illegal_sticky = sticky_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic
// against a behavioural model of the EX/MEM slot.
module tb_ex_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // model of the EX/MEM slot
    logic        m_valid, m_rw, m_ill, m_sticky, m_known;
    logic [4:0]  m_rd;
    logic [31:0] m_result, m_rs2;

    // newest in-flight producer of register r, else the register-file value
    function automatic logic [31:0] model_src(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return rf;
        if (m_valid && m_rw && m_rd == r) return m_result;
        if (bus.wb_reg_write && bus.wb_rd_idx == r) return bus.wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] op_ref(input logic [2:0] f3, input logic sub,
                                           input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return sub ? a - b : a + b;
            3'd4:    return a ^ b;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // advance one clock, updating the model with the pre-edge inputs
    task automatic step();
        logic [31:0] a, r2, b, res;
        logic        ill;
        a   = model_src(bus.id_rs1_idx, bus.id_rs1_val);
        r2  = model_src(bus.id_rs2_idx, bus.id_rs2_val);
        b   = bus.id_use_imm ? bus.id_imm : r2;
        ill = !(bus.id_funct3 inside {3'd0, 3'd4, 3'd6, 3'd7});
        res = bus.id_valid ? op_ref(bus.id_funct3, !bus.id_use_imm && bus.id_funct7b5, a, b) : 32'd0;
        @(posedge clk);
        if (rst) begin
            {m_valid, m_rw, m_ill, m_sticky} = '0;
            m_rd = '0; m_result = '0; m_rs2 = '0; m_known = 1'b1;
        end else if (bus.flush) begin
            m_valid = 1'b0; m_rw = 1'b0; m_ill = 1'b0; m_known = 1'b0;
        end else if (!bus.stall) begin
            m_valid  = bus.id_valid;
            m_rw     = bus.id_valid && bus.id_reg_write;
            m_ill    = bus.id_valid && ill;
            m_rd     = bus.id_rd_idx;
            m_result = res;
            m_rs2    = r2;
            m_known  = 1'b1;
            if (bus.id_valid && ill) m_sticky = 1'b1;
        end
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [31:0] v1,
                          input logic [4:0] r2, input logic [31:0] v2, input logic [31:0] imm,
                          input logic ui, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rd, input logic rw);
        bus.id_valid = v;   bus.id_rs1_idx = r1; bus.id_rs1_val = v1;
        bus.id_rs2_idx = r2; bus.id_rs2_val = v2; bus.id_imm = imm;
        bus.id_use_imm = ui; bus.id_funct3 = f3; bus.id_funct7b5 = f7;
        bus.id_rd_idx = rd; bus.id_reg_write = rw;
    endtask

    task automatic set_ctl(input logic [4:0] wrd, input logic wrw, input logic [31:0] wd,
                           input logic st, input logic fl);
        bus.wb_rd_idx = wrd; bus.wb_reg_write = wrw; bus.wb_data = wd;
        bus.stall = st; bus.flush = fl;
    endtask

    task automatic test_reset();
        set_id(1'b1, 5'd1, 32'h1234, 5'd2, 32'h55, 32'h7, 1'b0, 3'd0, 1'b0, 5'd9, 1'b1);
        set_ctl(5'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0)       begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.ex_valid); end
        checks++; if (bus.ex_rd_idx !== 5'd0)      begin errors++; $display("FAIL reset_rd got=%0d exp=0", bus.ex_rd_idx); end
        checks++; if (bus.ex_reg_write !== 1'b0)   begin errors++; $display("FAIL reset_rw got=%b exp=0", bus.ex_reg_write); end
        checks++; if (bus.ex_result !== 32'd0)     begin errors++; $display("FAIL reset_result got=%h exp=0", bus.ex_result); end
        checks++; if (bus.ex_rs2_fwd !== 32'd0)    begin errors++; $display("FAIL reset_rs2 got=%h exp=0", bus.ex_rs2_fwd); end
        checks++; if (bus.ex_illegal !== 1'b0)     begin errors++; $display("FAIL reset_illegal got=%b exp=0", bus.ex_illegal); end
        checks++; if (bus.illegal_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0", bus.illegal_sticky); end
        set_ctl(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_addi();
        set_id(1'b1, 5'd1, 32'd5, 5'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 3'd0, 1'b0, 5'd3, 1'b1);
        step();
        checks++; if (bus.ex_result !== 32'd4)   begin errors++; $display("FAIL addi_result got=%h exp=4", bus.ex_result); end
        checks++; if (bus.ex_valid !== 1'b1)     begin errors++; $display("FAIL addi_valid got=%b exp=1", bus.ex_valid); end
        checks++; if (bus.ex_reg_write !== 1'b1) begin errors++; $display("FAIL addi_rw got=%b exp=1", bus.ex_reg_write); end
        checks++; if (bus.ex_rd_idx !== 5'd3)    begin errors++; $display("FAIL addi_rd got=%0d exp=3", bus.ex_rd_idx); end
    endtask

    task automatic test_sub();
        set_id(1'b1, 5'd1, 32'd10, 5'd2, 32'd3, 32'h20, 1'b0, 3'd0, 1'b1, 5'd4, 1'b1);
        step();
        checks++; if (bus.ex_result !== 32'd7) begin errors++; $display("FAIL sub_result got=%h exp=7", bus.ex_result); end
        bus.id_use_imm = 1'b1;
        step();
        checks++; if (bus.ex_result !== 32'h2A) begin errors++; $display("FAIL addi_b30_result got=%h exp=2a", bus.ex_result); end
        set_id(1'b1, 5'd1, 32'd0, 5'd2, 32'd1, 32'h20, 1'b0, 3'd0, 1'b1, 5'd4, 1'b1);
        step();
        checks++; if (bus.ex_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_wrap got=%h exp=ffffffff", bus.ex_result); end
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 3'd0, 1'b0, 5'd5, 1'b1);
        step();
        checks++; if (bus.ex_result !== 32'd3) begin errors++; $display("FAIL b2b_add got=%h exp=3", bus.ex_result); end
        set_id(1'b1, 5'd5, 32'hDEAD, 5'd5, 32'hDEAD, 32'd0, 1'b0, 3'd4, 1'b0, 5'd6, 1'b1);
        set_ctl(5'd5, 1'b1, 32'd9, 1'b0, 1'b0);
        step();
        checks++; if (bus.ex_result !== 32'd0)  begin errors++; $display("FAIL b2b_xor got=%h exp=0", bus.ex_result); end
        checks++; if (bus.ex_rs2_fwd !== 32'd3) begin errors++; $display("FAIL b2b_rs2fwd got=%h exp=3", bus.ex_rs2_fwd); end
        set_ctl(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_wb_fwd();
        set_id(1'b1, 5'd7, 32'd0, 5'd0, 32'd0, 32'h0F, 1'b1, 3'd6, 1'b0, 5'd8, 1'b1);
        set_ctl(5'd7, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        step();
        checks++; if (bus.ex_result !== 32'hA5A5_A5AF) begin errors++; $display("FAIL wb_fwd got=%h exp=a5a5a5af", bus.ex_result); end
        set_id(1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 32'h10, 1'b1, 3'd6, 1'b0, 5'd9, 1'b1);
        set_ctl(5'd0, 1'b1, 32'hFF, 1'b0, 1'b0);
        step();
        checks++; if (bus.ex_result !== 32'h10) begin errors++; $display("FAIL wb_x0 got=%h exp=10", bus.ex_result); end
        set_ctl(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_stall_flush();
        set_id(1'b1, 5'd1, 32'h1F, 5'd0, 32'd0, 32'h30, 1'b1, 3'd7, 1'b0, 5'd9, 1'b1);
        step();
        checks++; if (bus.ex_result !== 32'h10) begin errors++; $display("FAIL and_result got=%h exp=10", bus.ex_result); end
        set_id(1'b1, 5'd2, 32'h55, 5'd3, 32'h66, 32'd1, 1'b1, 3'd0, 1'b0, 5'd10, 1'b1);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.ex_result !== 32'h10) begin errors++; $display("FAIL stall_result c%0d got=%h exp=10", i, bus.ex_result); end
            checks++; if (bus.ex_rd_idx !== 5'd9 || bus.ex_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold c%0d got rd=%0d v=%b exp rd=9 v=1", i, bus.ex_rd_idx, bus.ex_valid); end
        end
        bus.flush = 1'b1;
        step();
        checks++; if (bus.ex_valid !== 1'b0)     begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.ex_valid); end
        checks++; if (bus.ex_reg_write !== 1'b0) begin errors++; $display("FAIL flush_rw got=%b exp=0", bus.ex_reg_write); end
        set_ctl(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        set_id(1'b1, 5'd1, 32'h3, 5'd2, 32'h4, 32'd0, 1'b0, 3'd1, 1'b0, 5'd11, 1'b1);
        step();
        checks++; if (bus.ex_illegal !== 1'b1)     begin errors++; $display("FAIL ill_flag got=%b exp=1", bus.ex_illegal); end
        checks++; if (bus.ex_result !== 32'd0)     begin errors++; $display("FAIL ill_result got=%h exp=0", bus.ex_result); end
        checks++; if (bus.illegal_sticky !== 1'b1) begin errors++; $display("FAIL ill_sticky got=%b exp=1", bus.illegal_sticky); end
        bus.flush = 1'b1;
        step();
        checks++; if (bus.illegal_sticky !== 1'b1) begin errors++; $display("FAIL ill_sticky_flush got=%b exp=1", bus.illegal_sticky); end
        checks++; if (bus.ex_illegal !== 1'b0)     begin errors++; $display("FAIL ill_flush_flag got=%b exp=0", bus.ex_illegal); end
        bus.flush = 1'b0;
        set_id(1'b1, 5'd1, 32'h3, 5'd2, 32'h4, 32'd0, 1'b0, 3'd4, 1'b0, 5'd12, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_illegal, bus.illegal_sticky} !== 4'b0)
            begin errors++; $display("FAIL rst_flags got=%b exp=0000", {bus.ex_valid, bus.ex_reg_write, bus.ex_illegal, bus.illegal_sticky}); end
        checks++; if (bus.ex_result !== 32'd0 || bus.ex_rs2_fwd !== 32'd0 || bus.ex_rd_idx !== 5'd0)
            begin errors++; $display("FAIL rst_data got res=%h rs2=%h rd=%0d exp 0", bus.ex_result, bus.ex_rs2_fwd, bus.ex_rd_idx); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_id($urandom_range(9, 0) != 0, 5'($urandom_range(3, 0)), $urandom(),
                   5'($urandom_range(3, 0)), $urandom(),
                   $urandom_range(1, 0) ? $urandom() : 32'($urandom_range(15, 0)),
                   1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
                   5'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
            set_ctl(5'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), $urandom(),
                    $urandom_range(4, 0) == 0, $urandom_range(9, 0) == 0);
            rst = ($urandom_range(49, 0) == 0);
            step();
            checks++; if (bus.ex_valid !== m_valid)           begin errors++; $display("FAIL rnd_valid c%0d got=%b exp=%b", c, bus.ex_valid, m_valid); end
            checks++; if (bus.ex_reg_write !== m_rw)          begin errors++; $display("FAIL rnd_rw c%0d got=%b exp=%b", c, bus.ex_reg_write, m_rw); end
            checks++; if (bus.ex_illegal !== m_ill)           begin errors++; $display("FAIL rnd_ill c%0d got=%b exp=%b", c, bus.ex_illegal, m_ill); end
            checks++; if (bus.illegal_sticky !== m_sticky)    begin errors++; $display("FAIL rnd_sticky c%0d got=%b exp=%b", c, bus.illegal_sticky, m_sticky); end
            if (m_known) begin
                checks++; if (bus.ex_result !== m_result)     begin errors++; $display("FAIL rnd_result c%0d got=%h exp=%h", c, bus.ex_result, m_result); end
                checks++; if (bus.ex_rs2_fwd !== m_rs2)       begin errors++; $display("FAIL rnd_rs2 c%0d got=%h exp=%h", c, bus.ex_rs2_fwd, m_rs2); end
                checks++; if (bus.ex_rd_idx !== m_rd)         begin errors++; $display("FAIL rnd_rd c%0d got=%0d exp=%0d", c, bus.ex_rd_idx, m_rd); end
            end
        end
        rst = 1'b0;
        set_ctl(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        {m_valid, m_rw, m_ill, m_sticky, m_known} = '0;
        m_rd = '0; m_result = '0; m_rs2 = '0;
        set_id(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0);
        set_ctl(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_addi();
        test_sub();
        test_back_to_back();
        test_wb_fwd();
        test_stall_flush();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipelined RV32 core. It sits between the ID/EX boundary and the EX/MEM pipeline register.
- Decodes funct3/funct7 into the ALU one-hot enables and resolves operand forwarding from its own EX/MEM register and from WB.
- Drives the existing `alu` instance and registers the result plus control into EX/MEM with stall/flush handling.
- Supported ops: ADD, ADDI, SUB, XOR, XORI, OR, ORI, AND, ANDI. All other funct3 encodings are flagged illegal.

Parameters:
- XLEN, 32, datapath width; fixed by `alu`, so any other value is a configuration error.
- REG_IDX_W, 5, register index width.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID/EX slot holds a real instruction
- id_rs1_idx  in  REG_IDX_W  source register 1 index
- id_rs2_idx  in  REG_IDX_W  source register 2 index
- id_rs1_val  in  XLEN  register-file value of rs1 (x0 reads 0)
- id_rs2_val  in  XLEN  register-file value of rs2
- id_imm  in  XLEN  sign-extended I-immediate
- id_use_imm  in  1  1 = arg2 is imm (OP-IMM), 0 = rs2 (OP)
- id_funct3  in  3  instruction funct3
- id_funct7b5  in  1  instruction bit 30
- id_rd_idx  in  REG_IDX_W  destination index
- id_reg_write  in  1  instruction writes rd
- wb_rd_idx  in  REG_IDX_W  WB-stage destination
- wb_reg_write  in  1  WB stage writes this cycle
- wb_data  in  XLEN  WB write data
- stall  in  1  downstream cannot accept; hold EX/MEM
- flush  in  1  kill instruction entering EX/MEM
- ex_valid  out  1  EX/MEM slot valid
- ex_rd_idx  out  REG_IDX_W  registered rd
- ex_reg_write  out  1  registered write enable (0 when !ex_valid)
- ex_result  out  XLEN  registered ALU result
- ex_rs2_fwd  out  XLEN  registered forwarded rs2 (store data path)
- ex_illegal  out  1  registered unsupported-op flag
- illegal_sticky  out  1  set on first illegal op, cleared only by rst

Behaviour:
- Reset: synchronous, active-high. Every output register is 0 on the first edge with rst=1: ex_valid, ex_rd_idx, ex_reg_write, ex_result, ex_rs2_fwd, ex_illegal, illegal_sticky. rst overrides flush and stall.
- Latency: 1 cycle. Inputs sampled at edge N appear on ex_* after edge N.
- Forwarding is combinational and evaluated per source (rs1, rs2); priority, highest first:
  1. EX/MEM: ex_valid && ex_reg_write && ex_rd_idx!=0 && ex_rd_idx==rsN → ex_result.
  2. WB: wb_reg_write && wb_rd_idx!=0 && wb_rd_idx==rsN → wb_data.
  3. Otherwise → id_rsN_val.
  - Index 0 never forwards.
- Operand selection: arg1 = fwd rs1; arg2 = id_use_imm ? id_imm : fwd rs2. ex_rs2_fwd always captures fwd rs2, regardless of id_use_imm.
- Decode to exactly one enable:
  - funct3 000: sub_en if (!id_use_imm && id_funct7b5), else add_en (ADDI ignores bit 30).
  - funct3 100: xor_en. 110: or_en. 111: and_en.
  - 001/010/011/101: no enable, ALU yields 0, illegal=1.
  - No enable when !id_valid.
- Register update priority:
  1. rst.
  2. flush: ex_valid=0, ex_reg_write=0, ex_illegal=0; data fields don't-care. Flush wins over stall.
  3. stall: all EX/MEM registers hold. The ID inputs are expected to be held by upstream.
  4. Otherwise capture: ex_valid=id_valid, ex_reg_write=id_valid&&id_reg_write, ex_illegal=id_valid&&illegal.
- illegal_sticky sets when a capture loads ex_illegal=1. Unaffected by flush.
- Stalled cycles: EX/MEM forwarding keeps using the held ex_result, which is correct because ID is held too.
- Arithmetic wraps modulo 2^32; no overflow flag.
- Mid-operation reset: the in-flight instruction is discarded, with no partial state.

Decomposition:
- Package `riscv_pkg`:
  - funct3 constants: F3_ADD_SUB=000, F3_XOR=100, F3_OR=110, F3_AND=111.
  - `alu_op_t` packed struct {add_en, sub_en, xor_en, or_en, and_en}.
  - XLEN and REG_IDX_W defaults.
- Sub-module `alu_decode`: combinational, takes funct3, funct7b5, use_imm, valid and returns alu_op_t plus illegal.
- ex_stage contains the forwarding muxes, instantiates alu_decode and the existing `alu`, and owns the EX/MEM registers.

Test Plan:
- ADDI, rs1=x1 (val 5), imm=0xFFFFFFFF, rd=x3 → next cycle ex_result=4, ex_valid=1, ex_reg_write=1, ex_rd_idx=3.
- SUB x4=x1-x2 (10-3), funct7b5=1 → 7. Same fields with use_imm=1 → ADDI result 10+imm. Repeat the SUB with rs1=0, rs2=1 → ex_result=0xFFFFFFFF (wrap).
- Back-to-back: ADD x5=1+2, then XOR x6=x5^x5 with stale id_rs1_val=0xDEAD → EX forward gives 0. Set WB rd=x5 data=9 simultaneously → EX/MEM still wins.
- WB-only forward: wb x7=0xA5A5A5A5, OR rs1=x7 with 0x0F → 0xA5A5A5AF. Also wb_rd_idx=0 data=0xFF with rs1=x0 → no forward, uses 0.
- Stall then flush: capture AND result 0x10, assert stall 3 cycles with new ID inputs → ex_* unchanged. Assert stall+flush together → ex_valid=0, ex_reg_write=0.
- funct3=001 (SLL) → ex_illegal=1, ex_result=0, illegal_sticky=1 persists through flush. Assert rst → every output returns to 0 on the next edge.
